axilite_rw_arbiter: RTL
=======================

Name: axilite_rw_arbiter

Overview:
- Shares one single-port register bank between the AXI-lite write path (held write address + held write data) and the read path (held read address).
- Sits downstream of the per-channel address/data holding stages.
- Grants one transaction at a time with round-robin arbitration, drives the bank port, and returns the B/R responses.
- Pulses each holding stage's deassert input so the stage re-arms.

Parameters:
- ADDR_WIDTH, 32, width of held addresses.
- DATA_WIDTH, 32, register/data width (multiple of 8).
- NUM_REGS, 16, number of words in the bank; REG_AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wr_addr  in  ADDR_WIDTH  held write address
- wr_addr_ready  in  1  write address held
- wr_addr_deassert  out  1  one-cycle pulse, releases write address stage
- wr_data  in  DATA_WIDTH  held write data
- wr_strb  in  DATA_WIDTH/8  held write strobes
- wr_data_ready  in  1  write data held
- wr_data_deassert  out  1  one-cycle pulse, releases write data stage
- rd_addr  in  ADDR_WIDTH  held read address
- rd_addr_ready  in  1  read address held
- rd_addr_deassert  out  1  one-cycle pulse, releases read address stage
- reg_addr  out  REG_AW  bank word index
- reg_we  out  1  bank write enable
- reg_wdata  out  DATA_WIDTH  bank write data
- reg_wstrb  out  DATA_WIDTH/8  bank byte enables
- reg_re  out  1  bank read enable
- reg_rdata  in  DATA_WIDTH  bank read data, valid 1 cycle after reg_re
- bvalid  out  1  AXI B valid
- bready  in  1  AXI B ready
- bresp  out  2  AXI B response
- rvalid  out  1  AXI R valid
- rready  in  1  AXI R ready
- rdata  out  DATA_WIDTH  AXI R data
- rresp  out  2  AXI R response

Behaviour:
- Reset: single clock clk; synchronous active-high reset rst. While rst is high at a clk edge, all outputs are cleared to 0, state goes to IDLE, and last_grant = READ (so the first contended grant goes to write).
- Requests:
  - wr_req = wr_addr_ready & wr_data_ready.
  - rd_req = rd_addr_ready.
- Decode:
  - Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored.
  - Index >= NUM_REGS is out of range: resp 2'b10 (SLVERR) and no bank access.
  - In range: resp 2'b00 (OKAY).
- State machine (registered outputs):
  - IDLE:
    - If only wr_req: go to WR.
    - If only rd_req: go to RD.
    - If both: grant the opposite of last_grant.
    - last_grant updates on every grant.
  - WR:
    - One cycle; reg_we=1 only if in range.
    - reg_addr, reg_wdata, reg_wstrb are driven from the held values.
    - Then go to WR_RESP with bvalid=1 and bresp latched.
  - WR_RESP:
    - Hold bvalid/bresp until bready.
    - In the bvalid&bready cycle, pulse wr_addr_deassert and wr_data_deassert, clear bvalid, go to IDLE.
  - RD:
    - One cycle; reg_re=1 only if in range.
    - Then go to RD_WAIT.
  - RD_WAIT:
    - Capture rdata = reg_rdata (0 if out of range) and rresp.
    - rvalid=1; go to RD_RESP.
  - RD_RESP:
    - Hold rvalid/rdata/rresp until rready.
    - On handshake, pulse rd_addr_deassert, clear rvalid, go to IDLE.
- Latency: write request to bvalid is 2 cycles; read request to rvalid is 3 cycles.
- Back-to-back: after a deassert pulse, IDLE sees the stage's ready low on the next cycle. A new request is granted no earlier than 2 cycles after the handshake.
- Ordering and exclusivity:
  - reg_we and reg_re are never high together.
  - bvalid and rvalid are never high together.
  - Deassert pulses last exactly one cycle.
- Partial write request: wr_addr_ready without wr_data_ready, or the reverse, is not granted. It does not block reads.
- Reset mid-transaction: the transaction is abandoned and no deassert is issued. The holding stages are reset by the same rst.

Optional Feature:
- Macro AXILITE_ARB_STATS_EN.
- When defined, add outputs wr_count[15:0], rd_count[15:0] and err_count[15:0]:
  - wr_count increments on each B handshake.
  - rd_count increments on each R handshake.
  - err_count increments on each SLVERR handshake.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Write only: wr_addr=0x8, wr_data=0xDEADBEEF, wr_strb=4'hF, both ready -> reg_we=1 with reg_addr=2 one cycle later; bvalid=1 with bresp=0 next cycle; on bready, both write deassert pulses for 1 cycle.
- Read only: rd_addr=0xC, reg_rdata=0x12345678 after reg_re -> rvalid=1, rdata=0x12345678, rresp=0; rd_addr_deassert pulses on rready.
- Contention: wr_req and rd_req held high continuously from reset, bready=rready=1 -> grants alternate W, R, W, R; first grant is write.
- Out of range: NUM_REGS=16, rd_addr=0x40 -> reg_re never high, rresp=2'b10, rdata=0. With STATS_EN, err_count=1.
- Backpressure: bready low for 5 cycles -> bvalid and bresp stable for 5 cycles, no deassert, rd_req not granted until 2 cycles after the B handshake.
- Reset mid-read: assert rst during RD_WAIT -> next cycle all outputs 0, state IDLE; a new read after reset completes normally.

Source files
------------

// File: rtl/axilite_rw_arbiter_if.sv
// Bus bundle between the AXI-lite holding stages, the register bank and the
// read/write arbiter. The arbiter uses the slave modport; its environment uses master.
interface axilite_rw_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned REG_AW     = $clog2(NUM_REGS);

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_addr_ready;
  logic                  wr_addr_deassert;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_data_ready;
  logic                  wr_data_deassert;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_addr_ready;
  logic                  rd_addr_deassert;

  logic [REG_AW-1:0]     reg_addr;
  logic                  reg_we;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [STRB_WIDTH-1:0] reg_wstrb;
  logic                  reg_re;
  logic [DATA_WIDTH-1:0] reg_rdata;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport slave (
    input  wr_addr, wr_addr_ready, wr_data, wr_strb, wr_data_ready,
           rd_addr, rd_addr_ready, reg_rdata, bready, rready,
    output wr_addr_deassert, wr_data_deassert, rd_addr_deassert,
           reg_addr, reg_we, reg_wdata, reg_wstrb, reg_re,
           bvalid, bresp, rvalid, rdata, rresp
  );

  modport master (
    output wr_addr, wr_addr_ready, wr_data, wr_strb, wr_data_ready,
           rd_addr, rd_addr_ready, reg_rdata, bready, rready,
    input  wr_addr_deassert, wr_data_deassert, rd_addr_deassert,
           reg_addr, reg_we, reg_wdata, reg_wstrb, reg_re,
           bvalid, bresp, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axilite_rw_arbiter.sv
// Round-robin arbiter sharing one single-port register bank between AXI-lite writes and reads.
// Define AXILITE_ARB_STATS_EN to add saturating wr_count/rd_count/err_count outputs.
module axilite_rw_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  axilite_rw_arbiter_if.slave   bus
`ifdef AXILITE_ARB_STATS_EN
  ,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic [15:0]           err_count
`endif
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned REG_AW     = $clog2(NUM_REGS);
  localparam int unsigned IDX_W      = ADDR_WIDTH - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD      = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } state_t;

  state_t                state, state_n;
  logic                  last_grant_wr, last_grant_wr_n;

  logic [REG_AW-1:0]     reg_addr_q, reg_addr_n;
  logic                  reg_we_q, reg_we_n;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_n;
  logic [STRB_WIDTH-1:0] reg_wstrb_q, reg_wstrb_n;
  logic                  reg_re_q, reg_re_n;
  logic                  bvalid_q, bvalid_n;
  logic [1:0]            bresp_q, bresp_n;
  logic                  rvalid_q, rvalid_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [1:0]            rresp_q, rresp_n;
  logic                  wa_deassert_q, wa_deassert_n;
  logic                  wd_deassert_q, wd_deassert_n;
  logic                  ra_deassert_q, ra_deassert_n;

  // Word decode; the low two address bits select a byte lane and are ignored.
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic                  wr_req, rd_req, release_busy;
  logic                  unused_addr_lsbs;

  assign wr_idx           = bus.wr_addr[ADDR_WIDTH-1:2];
  assign rd_idx           = bus.rd_addr[ADDR_WIDTH-1:2];
  assign wr_in_range      = wr_idx < IDX_W'(NUM_REGS);
  assign rd_in_range      = rd_idx < IDX_W'(NUM_REGS);
  assign unused_addr_lsbs = ^{bus.wr_addr[1:0], bus.rd_addr[1:0]};

  assign wr_req       = bus.wr_addr_ready & bus.wr_data_ready;
  assign rd_req       = bus.rd_addr_ready;
  // Stages only drop ready the cycle after a release pulse, so hold off granting until then.
  assign release_busy = wa_deassert_q | wd_deassert_q | ra_deassert_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant_wr <= 1'b0;
      reg_addr_q    <= '0;
      reg_we_q      <= 1'b0;
      reg_wdata_q   <= '0;
      reg_wstrb_q   <= '0;
      reg_re_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= 2'b00;
      wa_deassert_q <= 1'b0;
      wd_deassert_q <= 1'b0;
      ra_deassert_q <= 1'b0;
    end else begin
      state         <= state_n;
      last_grant_wr <= last_grant_wr_n;
      reg_addr_q    <= reg_addr_n;
      reg_we_q      <= reg_we_n;
      reg_wdata_q   <= reg_wdata_n;
      reg_wstrb_q   <= reg_wstrb_n;
      reg_re_q      <= reg_re_n;
      bvalid_q      <= bvalid_n;
      bresp_q       <= bresp_n;
      rvalid_q      <= rvalid_n;
      rdata_q       <= rdata_n;
      rresp_q       <= rresp_n;
      wa_deassert_q <= wa_deassert_n;
      wd_deassert_q <= wd_deassert_n;
      ra_deassert_q <= ra_deassert_n;
    end
  end

  always_comb begin
    state_n         = state;
    last_grant_wr_n = last_grant_wr;
    reg_addr_n      = reg_addr_q;
    reg_we_n        = 1'b0;
    reg_wdata_n     = reg_wdata_q;
    reg_wstrb_n     = reg_wstrb_q;
    reg_re_n        = 1'b0;
    bvalid_n        = bvalid_q;
    bresp_n         = bresp_q;
    rvalid_n        = rvalid_q;
    rdata_n         = rdata_q;
    rresp_n         = rresp_q;
    wa_deassert_n   = 1'b0;
    wd_deassert_n   = 1'b0;
    ra_deassert_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!release_busy) begin
          if (wr_req && (!rd_req || !last_grant_wr)) begin
            state_n         = WR;
            last_grant_wr_n = 1'b1;
            reg_addr_n      = wr_idx[REG_AW-1:0];
            reg_we_n        = wr_in_range;
            reg_wdata_n     = bus.wr_data;
            reg_wstrb_n     = bus.wr_strb;
          end else if (rd_req) begin
            state_n         = RD;
            last_grant_wr_n = 1'b0;
            reg_addr_n      = rd_idx[REG_AW-1:0];
            reg_re_n        = rd_in_range;
          end
        end
      end
      WR: begin
        state_n  = WR_RESP;
        bvalid_n = 1'b1;
        bresp_n  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      WR_RESP: begin
        if (bus.bready) begin
          state_n       = IDLE;
          bvalid_n      = 1'b0;
          wa_deassert_n = 1'b1;
          wd_deassert_n = 1'b1;
        end
      end
      RD: begin
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        state_n  = RD_RESP;
        rvalid_n = 1'b1;
        rdata_n  = rd_in_range ? bus.reg_rdata : '0;
        rresp_n  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      RD_RESP: begin
        if (bus.rready) begin
          state_n       = IDLE;
          rvalid_n      = 1'b0;
          ra_deassert_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.reg_addr         = reg_addr_q;
  assign bus.reg_we           = reg_we_q;
  assign bus.reg_wdata        = reg_wdata_q;
  assign bus.reg_wstrb        = reg_wstrb_q;
  assign bus.reg_re           = reg_re_q;
  assign bus.bvalid           = bvalid_q;
  assign bus.bresp            = bresp_q;
  assign bus.rvalid           = rvalid_q;
  assign bus.rdata            = rdata_q;
  assign bus.rresp            = rresp_q;
  assign bus.wr_addr_deassert = wa_deassert_q;
  assign bus.wr_data_deassert = wd_deassert_q;
  assign bus.rd_addr_deassert = ra_deassert_q;

`ifdef AXILITE_ARB_STATS_EN
  // Saturating handshake counters.
  logic b_hs, r_hs, err_hs;

  assign b_hs   = bvalid_q & bus.bready;
  assign r_hs   = rvalid_q & bus.rready;
  assign err_hs = (b_hs && bresp_q == RESP_SLVERR) || (r_hs && rresp_q == RESP_SLVERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count  <= 16'h0000;
      rd_count  <= 16'h0000;
      err_count <= 16'h0000;
    end else begin
      if (b_hs && wr_count != 16'hFFFF)    wr_count  <= wr_count + 16'h0001;
      if (r_hs && rd_count != 16'hFFFF)    rd_count  <= rd_count + 16'h0001;
      if (err_hs && err_count != 16'hFFFF) err_count <= err_count + 16'h0001;
    end
  end
`endif

endmodule
